// File: rtl/d_flip_flop_async.sv
// D-type storage register with synchronous reset, preset and true/complement outputs.
// Build macro DFF_ASYNC_PRESET_EN turns preset into an asynchronous set (preset > reset > D).
module d_flip_flop_async #(
  parameter int unsigned           WIDTH        = 1,
  parameter logic [WIDTH-1:0]      RESET_VALUE  = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0]      PRESET_VALUE = {WIDTH{1'b1}}
) (
  input  logic [WIDTH-1:0] D,
  input  logic             clock,
  input  logic             reset,
  input  logic             preset,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] _Q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

`ifdef DFF_ASYNC_PRESET_EN

  // Clocked load: reset has priority over D; preset is handled on the async path.
  always_comb begin
    q_d = D;
    if (reset) begin
      q_d = RESET_VALUE;
    end else begin
      q_d = D;
    end
  end

  // Asynchronous preset overrides everything while held high.
  always_ff @(posedge clock or posedge preset) begin
    if (preset) begin
      q_q <= PRESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

`else

  // Clocked load priority: reset, then preset, then D.
  always_comb begin
    q_d = D;
    if (reset) begin
      q_d = RESET_VALUE;
    end else if (preset) begin
      q_d = PRESET_VALUE;
    end else begin
      q_d = D;
    end
  end

  // State register; the block always loads on the rising edge.
  always_ff @(posedge clock) begin
    q_q <= q_d;
  end

`endif

  assign Q  = q_q;
  assign _Q = ~q_q;

endmodule

// File: tb/tb_d_flip_flop_async.sv
// Scoreboard bench for d_flip_flop_async (WIDTH=1); follows the documented timeline,
// then applies random reset/preset traffic. Checks adapt when DFF_ASYNC_PRESET_EN is defined.
module tb_d_flip_flop_async;

  logic [0:0] d;
  logic       clock;
  logic       reset;
  logic       preset;
  logic [0:0] q;
  logic [0:0] q_n;

  int vectors;
  int miscompares;
  logic [0:0] exp_q[$];
  logic [0:0] e;

  d_flip_flop_async #(.WIDTH(1)) dut (
    .D      (d),
    .clock  (clock),
    .reset  (reset),
    .preset (preset),
    .Q      (q),
    ._Q     (q_n)
  );

  initial begin
    clock = 1'b0;
    forever #10 clock = ~clock;
  end

  initial begin
    d = 1'b0;
    forever #20 d = ~d;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required summary");
    $fatal(1);
  end

  // Reference behaviour of the next stored value at a rising edge.
  function automatic logic [0:0] model_next(logic r, logic p, logic [0:0] dv);
`ifdef DFF_ASYNC_PRESET_EN
    if (p) return 1'b1;
    else if (r) return 1'b0;
    else return dv;
`else
    if (r) return 1'b0;
    else if (p) return 1'b1;
    else return dv;
`endif
  endfunction

  task automatic test_reset;
    reset  = 1'b1;
    preset = 1'b1;
`ifdef DFF_ASYNC_PRESET_EN
    #1;
    vectors++;
    if (q !== 1'b1) begin
      miscompares++;
      $display("FAIL async_preset_t0: Q=%b required 1", q);
    end
`endif
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      exp_q.push_back(model_next(reset, preset, d));
      #1;
      e = exp_q.pop_front();
      vectors++;
      if (q !== e) begin
        miscompares++;
        $display("FAIL reset_over_preset Q at %0t: got %b required %b", $time, q, e);
      end
      vectors++;
      if (q_n !== ~e) begin
        miscompares++;
        $display("FAIL reset_over_preset _Q at %0t: got %b required %b", $time, q_n, ~e);
      end
    end
    #9;
  endtask

  task automatic test_preset;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      exp_q.push_back(model_next(reset, preset, d));
      #1;
      e = exp_q.pop_front();
      vectors++;
      if (q !== e) begin
        miscompares++;
        $display("FAIL preset Q at %0t: got %b required %b", $time, q, e);
      end
      vectors++;
      if (q_n !== ~e) begin
        miscompares++;
        $display("FAIL preset _Q at %0t: got %b required %b", $time, q_n, ~e);
      end
    end
    #9;
  endtask

  task automatic test_follow_d;
    preset = 1'b0;
`ifdef DFF_ASYNC_PRESET_EN
    #1;
    vectors++;
    if (q !== 1'b1) begin
      miscompares++;
      $display("FAIL preset_release_hold: Q=%b required 1", q);
    end
    #8;
`else
    #9;
`endif
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      exp_q.push_back(model_next(reset, preset, d));
      #1;
      e = exp_q.pop_front();
      vectors++;
      if (q !== e) begin
        miscompares++;
        $display("FAIL follow_d Q at %0t: got %b required %b", $time, q, e);
      end
      vectors++;
      if (q_n !== ~e) begin
        miscompares++;
        $display("FAIL follow_d _Q at %0t: got %b required %b", $time, q_n, ~e);
      end
      vectors++;
      if (q !== ((i % 2 == 0) ? 1'b1 : 1'b0)) begin
        miscompares++;
        $display("FAIL follow_d_pattern at %0t: got %b required %b", $time, q, (i % 2 == 0) ? 1'b1 : 1'b0);
      end
    end
    #9;
  endtask

  task automatic test_mid_reset;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      exp_q.push_back(model_next(reset, preset, d));
      #1;
      e = exp_q.pop_front();
      vectors++;
      if (q !== e) begin
        miscompares++;
        $display("FAIL mid_reset Q at %0t: got %b required %b", $time, q, e);
      end
      vectors++;
      if (q_n !== ~e) begin
        miscompares++;
        $display("FAIL mid_reset _Q at %0t: got %b required %b", $time, q_n, ~e);
      end
    end
    #9;
  endtask

  task automatic test_preset_under_reset;
    preset = 1'b1;
`ifdef DFF_ASYNC_PRESET_EN
    #1;
    vectors++;
    if (q !== 1'b1) begin
      miscompares++;
      $display("FAIL async_preset_immediate: Q=%b required 1", q);
    end
`endif
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      exp_q.push_back(model_next(reset, preset, d));
      #1;
      e = exp_q.pop_front();
      vectors++;
      if (q !== e) begin
        miscompares++;
        $display("FAIL preset_under_reset Q at %0t: got %b required %b", $time, q, e);
      end
      vectors++;
      if (q_n !== ~e) begin
        miscompares++;
        $display("FAIL preset_under_reset _Q at %0t: got %b required %b", $time, q_n, ~e);
      end
    end
    #9;
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      exp_q.push_back(model_next(reset, preset, d));
      #1;
      e = exp_q.pop_front();
      vectors++;
      if (q !== e) begin
        miscompares++;
        $display("FAIL back_to_back Q at %0t: got %b required %b", $time, q, e);
      end
      vectors++;
      if (q_n !== ~e) begin
        miscompares++;
        $display("FAIL back_to_back _Q at %0t: got %b required %b", $time, q_n, ~e);
      end
      #4;
      reset  = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
      preset = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_preset();
    test_follow_d();
    test_mid_reset();
    test_preset_under_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
